issue_pair_buffer: RTL and testbench

- Fetch-side producer for the dual-lane decode stage. It buffers fetched instruction words in a circular queue and issues them as an A/B lane pair to the dual control decoder.
- Only ALU-type (R-type 0110011, I-type ALU 0010011) pairs without intra-pair hazards are dual-issued. Otherwise lane A issues alone and lane B carries a NOP.
- Honours the decoder's `trigger` stall and a pipeline flush.

---
 rtl/riscv_pkg.sv | 26 ++
 rtl/pair_hazard_check.sv | 16 +
 rtl/issue_pair_buffer.sv | 78 +++++++
 tb/tb_issue_pair_buffer.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: opcode constants, NOP word and instruction field helpers shared by the decode stage.
package riscv_pkg;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE_ALU = 7'b0010011;
    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    function automatic logic [6:0] opcode(input logic [31:0] w);
        return w[6:0];
    endfunction

    function automatic logic [4:0] rd(input logic [31:0] w);
        return w[11:7];
    endfunction

    function automatic logic [4:0] rs1(input logic [31:0] w);
        return w[19:15];
    endfunction

    function automatic logic [4:0] rs2(input logic [31:0] w);
        return w[24:20];
    endfunction

    function automatic logic is_alu(input logic [31:0] w);
        return opcode(w) == OP_RTYPE || opcode(w) == OP_ITYPE_ALU;
    endfunction
endpackage

// File: rtl/pair_hazard_check.sv
// pair_hazard_check: decides whether two queued words may issue together as an ALU pair.
module pair_hazard_check
    import riscv_pkg::*;
(
    input  logic [31:0] instr_a,
    input  logic [31:0] instr_b,
    output logic        pair_ok
);
    logic [4:0] rd_a;
    logic       b_reads_rd_a;
    assign rd_a = rd(instr_a);
    // x0 as destination never creates a dependence
    assign b_reads_rd_a = rs1(instr_b) == rd_a || (opcode(instr_b) == OP_RTYPE && rs2(instr_b) == rd_a);
    assign pair_ok = is_alu(instr_a) && is_alu(instr_b) &&
                     (rd_a == 5'd0 || (!b_reads_rd_a && rd(instr_b) != rd_a));
endmodule

// File: rtl/issue_pair_buffer.sv
// issue_pair_buffer: circular fetch queue issuing A/B lane pairs to the dual decoder.
module issue_pair_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH = 8,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [1:0]                 in_count,
    input  logic [DATA_WIDTH-1:0]      in_instr0,
    input  logic [DATA_WIDTH-1:0]      in_instr1,
    output logic                       in_ready,
    input  logic                       trigger,
    input  logic                       flush,
    output logic [DATA_WIDTH-1:0]      instrA,
    output logic [DATA_WIDTH-1:0]      instrB,
    output logic [1:0]                 issue_valid,
    output logic [$clog2(DEPTH):0]     occupancy
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         rd_ptr, wr_ptr, push_cnt, pop_cnt;
    logic [AW-1:0]         rd_idx, rd_idx1, wr_idx, wr_idx1;
    logic [DATA_WIDTH-1:0] head, head_next;
    logic                  pair_ok;

    assign occupancy = wr_ptr - rd_ptr;
    assign in_ready  = occupancy <= PW'(DEPTH - 2);
    assign rd_idx    = rd_ptr[AW-1:0];
    assign rd_idx1   = rd_idx + AW'(1);
    assign wr_idx    = wr_ptr[AW-1:0];
    assign wr_idx1   = wr_idx + AW'(1);
    assign head      = mem[rd_idx];
    assign head_next = mem[rd_idx1];

    pair_hazard_check u_hazard (
        .instr_a (head[31:0]),
        .instr_b (head_next[31:0]),
        .pair_ok (pair_ok)
    );

    // in_count of 3 is treated as no offer
    always_comb begin
        push_cnt = (!in_ready || flush) ? PW'(0) : in_count == 2'd1 ? PW'(1) : in_count == 2'd2 ? PW'(2) : PW'(0);
        pop_cnt  = (flush || trigger || occupancy == '0) ? PW'(0) :
                   (occupancy >= PW'(2) && pair_ok) ? PW'(2) : PW'(1);
    end

    always_ff @(posedge clk) begin
        if (push_cnt != '0) mem[wr_idx] <= in_instr0;
        if (push_cnt == PW'(2)) mem[wr_idx1] <= in_instr1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            instrA      <= NOP_INSTR;
            instrB      <= NOP_INSTR;
            issue_valid <= 2'b00;
        end else if (flush) begin
            rd_ptr      <= wr_ptr;
            instrA      <= NOP_INSTR;
            instrB      <= NOP_INSTR;
            issue_valid <= 2'b00;
        end else begin
            wr_ptr <= wr_ptr + push_cnt;
            rd_ptr <= rd_ptr + pop_cnt;
            if (!trigger) begin
                instrA      <= pop_cnt != '0 ? head : NOP_INSTR;
                instrB      <= pop_cnt == PW'(2) ? head_next : NOP_INSTR;
                issue_valid <= {pop_cnt != '0, pop_cnt == PW'(2)};
            end
        end
    end
endmodule

// File: tb/tb_issue_pair_buffer.sv
// tb_issue_pair_buffer: directed test-plan scenarios plus random traffic against a queue model.
module tb_issue_pair_buffer;
    localparam int DEPTH = 8;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 0, rst_n = 0, trigger = 0, flush = 0, in_ready;
    logic [1:0]  in_count = 0, issue_valid;
    logic [31:0] in_instr0 = 0, in_instr1 = 0, instrA, instrB;
    logic [3:0]  occupancy;

    int tests = 0, fails = 0;
    logic [31:0] q[$];
    logic [31:0] ma = NOP, mb = NOP;
    logic [1:0]  mv = 2'b00;

    issue_pair_buffer dut (
        .clk(clk), .rst_n(rst_n), .in_count(in_count), .in_instr0(in_instr0),
        .in_instr1(in_instr1), .in_ready(in_ready), .trigger(trigger), .flush(flush),
        .instrA(instrA), .instrB(instrB), .issue_valid(issue_valid), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit ok_ref(input logic [31:0] a, input logic [31:0] b);
        int op_a = a % 128, op_b = b % 128;
        int rd_a = (a / 128) % 32, rd_b = (b / 128) % 32;
        int s1_b = (b / 32768) % 32, s2_b = (b / 1048576) % 32;
        bit alu_a = op_a == 'h33 || op_a == 'h13;
        bit alu_b = op_b == 'h33 || op_b == 'h13;
        if (!(alu_a && alu_b)) return 0;
        if (rd_a == 0) return 1;
        if (s1_b == rd_a || rd_b == rd_a) return 0;
        if (op_b == 'h33 && s2_b == rd_a) return 0;
        return 1;
    endfunction

    function automatic logic [31:0] rnd_instr();
        int k = $urandom_range(0, 5);
        logic [6:0] op = k < 2 ? 7'h33 : k < 4 ? 7'h13 : k == 4 ? 7'h03 : 7'h63;
        logic [6:0] f7 = 7'($urandom_range(0, 127));
        logic [2:0] f3 = 3'($urandom_range(0, 7));
        logic [4:0] r2 = 5'($urandom_range(0, 3)), r1 = 5'($urandom_range(0, 3)), rdd = 5'($urandom_range(0, 3));
        return {f7, r2, r1, f3, rdd, op};
    endfunction

    task automatic step(input int cnt, input logic [31:0] w0, input logic [31:0] w1, input logic trig, input logic fl);
        int occ, n;
        bit rdy;
        @(negedge clk);
        in_count = 2'(cnt); in_instr0 = w0; in_instr1 = w1; trigger = trig; flush = fl;
        #1;
        occ = q.size();
        rdy = occ <= DEPTH - 2;
        check("in_ready", 32'(in_ready), 32'(rdy));
        check("occ_pre", 32'(occupancy), 32'(occ));
        if (fl) begin
            q.delete(); ma = NOP; mb = NOP; mv = 2'b00;
        end else begin
            n = trig ? 0 : occ == 0 ? 0 : (occ >= 2 && ok_ref(q[0], q[1])) ? 2 : 1;
            if (!trig) begin
                ma = n > 0 ? q[0] : NOP;
                mb = n == 2 ? q[1] : NOP;
                mv = {n > 0, n == 2};
            end
            repeat (n) void'(q.pop_front());
            if (rdy && (cnt == 1 || cnt == 2)) begin
                q.push_back(w0);
                if (cnt == 2) q.push_back(w1);
            end
        end
        @(posedge clk);
        #1;
        check("instrA", instrA, ma);
        check("instrB", instrB, mb);
        check("valid", 32'(issue_valid), 32'(mv));
        check("occ_post", 32'(occupancy), 32'(q.size()));
    endtask

    initial begin
        #12;
        check("rst_a", instrA, NOP);
        check("rst_b", instrB, NOP);
        check("rst_valid", 32'(issue_valid), 0);
        check("rst_occ", 32'(occupancy), 0);
        check("rst_ready", 32'(in_ready), 1);
        @(negedge clk) rst_n = 1;

        step(2, 32'h003100B3, 32'h00628233, 0, 0);
        step(0, 0, 0, 0, 0);
        check("tp1_valid", 32'(issue_valid), 3);
        check("tp1_a", instrA, 32'h003100B3);
        check("tp1_b", instrB, 32'h00628233);

        step(2, 32'h00500093, 32'h00108133, 0, 0);
        step(0, 0, 0, 0, 0);
        check("raw_a", instrA, 32'h00500093);
        check("raw_b", instrB, NOP);
        check("raw_valid", 32'(issue_valid), 2);
        step(0, 0, 0, 0, 0);
        check("raw_a2", instrA, 32'h00108133);

        step(2, 32'h00012283, 32'h00838333, 0, 0);
        step(0, 0, 0, 0, 0);
        check("lw_a", instrA, 32'h00012283);
        check("lw_valid", 32'(issue_valid), 2);
        step(0, 0, 0, 0, 0);
        check("lw_a2", instrA, 32'h00838333);

        for (int i = 0; i < 4; i++) step(2, rnd_instr(), rnd_instr(), 1, 0);
        check("full_ready", 32'(in_ready), 0);
        check("full_occ", 32'(occupancy), 8);
        step(2, rnd_instr(), rnd_instr(), 1, 0);
        for (int i = 0; i < 9; i++) step(0, 0, 0, 0, 0);

        step(1, rnd_instr(), 0, 1, 0);
        for (int i = 0; i < 3; i++) step(2, rnd_instr(), rnd_instr(), 1, 0);
        check("occ7_ready", 32'(in_ready), 0);
        step(1, rnd_instr(), 0, 1, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0);

        step(1, rnd_instr(), 0, 1, 0);
        step(2, rnd_instr(), rnd_instr(), 1, 0);
        step(2, rnd_instr(), rnd_instr(), 1, 0);
        step(2, rnd_instr(), rnd_instr(), 1, 1);
        check("flush_occ", 32'(occupancy), 0);
        check("flush_valid", 32'(issue_valid), 0);

        for (int i = 0; i < 1500; i++)
            step($urandom_range(0, 3), rnd_instr(), rnd_instr(),
                 $urandom_range(0, 3) == 0, $urandom_range(0, 31) == 0);

        for (int i = 0; i < 4; i++) step(2, 32'h003100B3, 32'h00628233, 1, 0);
        step(0, 0, 0, 0, 0);
        #2 rst_n = 0;
        #1;
        check("arst_a", instrA, NOP);
        check("arst_b", instrB, NOP);
        check("arst_valid", 32'(issue_valid), 0);
        check("arst_occ", 32'(occupancy), 0);
        check("arst_ready", 32'(in_ready), 1);
        @(negedge clk) rst_n = 1;
        q.delete(); ma = NOP; mb = NOP; mv = 2'b00;
        for (int i = 0; i < 20; i++)
            step($urandom_range(0, 2), rnd_instr(), rnd_instr(), 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
